spi_rx_deser: RTL and testbench

SPI_RX_DESER -- requirements
Module: spi_rx_deser

---
 rtl/spi_rx_deser.sv | 111 +++++++++++
 tb/tb_spi_rx_deser.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_deser.sv
// Serial-to-parallel receiver: collects WIDTH strobed bits into a word and
// holds it for a consumer with acknowledge, overrun detection and frame abort.
module spi_rx_deser #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in,
  input  logic                             enable,
  input  logic                             clear,
  input  logic                             out_ack,
  output logic [WIDTH-1:0]                 out,
  output logic                             out_valid,
  output logic                             finish,
  output logic                             overrun,
  output logic                             busy,
  output logic [$clog2(WIDTH+1)-1:0]       bit_cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] out_d;
  logic             valid_d, finish_d, overrun_d, busy_d;
  logic [CW-1:0]    cnt_d;

  // Shift register with the incoming bit inserted at the end that matches the bit order
  always_comb begin
    if (MSB_FIRST != 0) shifted_c = {sr_q[WIDTH-2:0], in};
    else                shifted_c = {in, sr_q[WIDTH-1:1]};
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = bit_cnt;
    out_d     = out;
    valid_d   = out_valid & ~out_ack;
    finish_d  = 1'b0;
    overrun_d = overrun;

    if (clear) begin
      state_d   = IDLE;
      sr_d      = '0;
      cnt_d     = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          sr_d    = shifted_c;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == CW'(WIDTH - 1)) begin
            out_d    = shifted_c;
            valid_d  = 1'b1;
            finish_d = 1'b1;
            // An unacknowledged word is being replaced
            if (out_valid && !out_ack) overrun_d = 1'b1;
            sr_d     = '0;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            sr_d  = shifted_c;
            cnt_d = bit_cnt + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == SHIFT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      finish    <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt   <= cnt_d;
      out       <= out_d;
      out_valid <= valid_d;
      finish    <= finish_d;
      overrun   <= overrun_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_rx_deser.sv
// Scoreboard bench for spi_rx_deser: one MSB-first and one LSB-first instance
// share the same stimulus; completed words are checked by per-instance monitors.
module tb_spi_rx_deser;

  logic clk = 1'b0;
  logic rst_n, in_b, enable, clear, out_ack;

  logic [9:0] out_m, out_l;
  logic       valid_m, valid_l, finish_m, finish_l, overrun_m, overrun_l, busy_m, busy_l;
  logic [3:0] cnt_m, cnt_l;

  int checks = 0;
  int failures = 0;

  logic [9:0] q_m[$];
  logic [9:0] q_l[$];

  localparam logic [9:0] STREAM_A = 10'b1011001110;
  localparam logic [9:0] STREAM_F = 10'h3FF;

  spi_rx_deser #(.WIDTH(10), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in(in_b), .enable(enable), .clear(clear), .out_ack(out_ack),
    .out(out_m), .out_valid(valid_m), .finish(finish_m), .overrun(overrun_m),
    .busy(busy_m), .bit_cnt(cnt_m)
  );

  spi_rx_deser #(.WIDTH(10), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in(in_b), .enable(enable), .clear(clear), .out_ack(out_ack),
    .out(out_l), .out_valid(valid_l), .finish(finish_l), .overrun(overrun_l),
    .busy(busy_l), .bit_cnt(cnt_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every finish pulse must match the next expected word
  always @(negedge clk) begin
    if (rst_n && finish_m) begin
      checks++;
      if (q_m.size() == 0) begin
        failures++;
        $display("FAIL msb_unexpected_finish: got out=0x%0h expected no finish", out_m);
      end else begin
        logic [9:0] e;
        e = q_m.pop_front();
        if (out_m !== e || valid_m !== 1'b1) begin
          failures++;
          $display("FAIL msb_word: got out=0x%0h valid=%0b expected out=0x%0h valid=1", out_m, valid_m, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && finish_l) begin
      checks++;
      if (q_l.size() == 0) begin
        failures++;
        $display("FAIL lsb_unexpected_finish: got out=0x%0h expected no finish", out_l);
      end else begin
        logic [9:0] e;
        e = q_l.pop_front();
        if (out_l !== e || valid_l !== 1'b1) begin
          failures++;
          $display("FAIL lsb_word: got out=0x%0h valid=%0b expected out=0x%0h valid=1", out_l, valid_l, e);
        end
      end
    end
  end

  // Send v[hi] down to v[lo], one bit per cycle
  task automatic send_range(input logic [9:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      in_b   = v[i];
      enable = 1'b1;
      @(posedge clk); #1;
    end
    enable = 1'b0;
    in_b   = 1'b0;
  endtask

  task automatic expect_word(input logic [9:0] em, input logic [9:0] el);
    q_m.push_back(em);
    q_l.push_back(el);
  endtask

  task automatic ack_once();
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
  endtask

  task automatic chk_idle_pair(input string name);
    chk({name, "_cnt_m"},  32'(cnt_m),  32'd0);
    chk({name, "_busy_m"}, 32'(busy_m), 32'd0);
    chk({name, "_cnt_l"},  32'(cnt_l),  32'd0);
    chk({name, "_busy_l"}, 32'(busy_l), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_b = 1'b0; enable = 1'b0; clear = 1'b0; out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_m", 32'(out_m), 32'h0);
    chk("rst_valid_m", 32'(valid_m), 32'h0);
    chk("rst_overrun_m", 32'(overrun_m), 32'h0);
    chk("rst_finish_m", 32'(finish_m), 32'h0);
    chk_idle_pair("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, with a mid-frame look at the counter
    expect_word(10'h2CE, 10'h1CD);
    send_range(STREAM_A, 9, 5);
    chk("mid_cnt_m", 32'(cnt_m), 32'd5);
    chk("mid_busy_m", 32'(busy_m), 32'd1);
    chk("mid_out_hidden_m", 32'(out_m), 32'h0);
    send_range(STREAM_A, 4, 0);
    chk_idle_pair("a_done");
    chk("a_out_m", 32'(out_m), 32'h2CE);
    chk("a_out_l", 32'(out_l), 32'h1CD);
    chk("a_valid_m", 32'(valid_m), 32'd1);
    @(posedge clk); #1;
    chk("a_finish_drop_m", 32'(finish_m), 32'd0);

    ack_once();
    chk("ack_valid_m", 32'(valid_m), 32'd0);
    chk("ack_valid_l", 32'(valid_l), 32'd0);
    ack_once();
    chk("ack_idle_valid_m", 32'(valid_m), 32'd0);
    chk("ack_idle_out_m", 32'(out_m), 32'h2CE);

    // Unacked word followed back-to-back by 3FF
    expect_word(10'h2CE, 10'h1CD);
    send_range(STREAM_A, 9, 0);
    chk("ovr_first_m", 32'(overrun_m), 32'd0);
    expect_word(10'h3FF, 10'h3FF);
    send_range(STREAM_F, 9, 0);
    chk("ovr_set_m", 32'(overrun_m), 32'd1);
    chk("ovr_set_l", 32'(overrun_l), 32'd1);
    chk("ovr_out_m", 32'(out_m), 32'h3FF);
    ack_once();
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_sticky_m", 32'(overrun_m), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_overrun_m", 32'(overrun_m), 32'd0);
    chk("clr_valid_m", 32'(valid_m), 32'd0);
    chk("clr_out_kept_m", 32'(out_m), 32'h3FF);

    // Ack coincident with completion: new word held, no overrun
    expect_word(10'h2CE, 10'h1CD);
    send_range(STREAM_A, 9, 0);
    expect_word(10'h3FF, 10'h3FF);
    send_range(STREAM_F, 9, 1);
    out_ack = 1'b1;
    send_range(STREAM_F, 0, 0);
    out_ack = 1'b0;
    chk("ackc_valid_m", 32'(valid_m), 32'd1);
    chk("ackc_overrun_m", 32'(overrun_m), 32'd0);
    chk("ackc_overrun_l", 32'(overrun_l), 32'd0);
    ack_once();

    // Stall for 5 cycles after bit 4
    expect_word(10'h2CE, 10'h1CD);
    send_range(STREAM_A, 9, 6);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_cnt_m", 32'(cnt_m), 32'd4);
    chk("stall_busy_m", 32'(busy_m), 32'd1);
    chk("stall_cnt_l", 32'(cnt_l), 32'd4);
    chk("stall_out_m", 32'(out_m), 32'h3FF);
    send_range(STREAM_A, 5, 0);
    chk("stall_out_done_m", 32'(out_m), 32'h2CE);
    chk("stall_out_done_l", 32'(out_l), 32'h1CD);

    // Clear with enable at bit_cnt=6: bit dropped, no finish
    send_range(STREAM_A, 9, 4);
    chk("clr6_cnt_m", 32'(cnt_m), 32'd6);
    clear = 1'b1; enable = 1'b1; in_b = 1'b1; out_ack = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; enable = 1'b0; in_b = 1'b0; out_ack = 1'b0;
    chk_idle_pair("clr6");
    chk("clr6_out_m", 32'(out_m), 32'h2CE);
    chk("clr6_out_l", 32'(out_l), 32'h1CD);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset between edges at bit_cnt=7
    send_range(STREAM_A, 9, 3);
    chk("rst7_cnt_m", 32'(cnt_m), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_m", 32'(out_m), 32'h0);
    chk("arst_out_l", 32'(out_l), 32'h0);
    chk("arst_valid_m", 32'(valid_m), 32'd0);
    chk("arst_overrun_m", 32'(overrun_m), 32'd0);
    chk("arst_finish_m", 32'(finish_m), 32'd0);
    chk_idle_pair("arst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_cnt_m", 32'(cnt_m), 32'd0);
    expect_word(10'h2CE, 10'h1CD);
    send_range(STREAM_A, 9, 0);
    chk("post_rst_out_m", 32'(out_m), 32'h2CE);
    chk("post_rst_out_l", 32'(out_l), 32'h1CD);
    repeat (2) @(posedge clk);
    #1;

    chk("pending_m", 32'(q_m.size()), 32'd0);
    chk("pending_l", 32'(q_l.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
